// File: rtl/sram_march_bist.sv
// March C- built-in self-test for the test-chip SRAM macros on the shared port-0 bus.
// One macro is selected per run; mismatches are counted and the first one is captured.
module sram_march_bist #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned WMASK_WIDTH  = 4,
   parameter int unsigned NUM_CHIPS    = 16,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [3:0]             chip_sel,
   input  logic [ADDR_WIDTH-1:0]  last_addr,
   input  logic [DATA_WIDTH-1:0]  cmp_mask,
   input  logic [DATA_WIDTH-1:0]  rdata_in,
   output logic [ADDR_WIDTH-1:0]  addr0,
   output logic [DATA_WIDTH-1:0]  din0,
   output logic                   web0,
   output logic [WMASK_WIDTH-1:0] wmask0,
   output logic [NUM_CHIPS-1:0]   csb0,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [15:0]            fail_count,
   output logic [ADDR_WIDTH-1:0]  fail_addr,
   output logic [DATA_WIDTH-1:0]  fail_expected,
   output logic [DATA_WIDTH-1:0]  fail_actual,
   output logic [2:0]             march_elem
);

   localparam int unsigned CntW = $clog2(READ_LATENCY + 1);

   typedef enum logic [2:0] {StIdle, StWrite, StRead, StWait, StNext, StDone} state_e;

   state_e                 state_q, state_d;
   logic [2:0]             elem_q, elem_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]  last_q, last_d;
   logic [CntW-1:0]        wait_q, wait_d;
   logic [3:0]             chip_q, chip_d;
   logic [DATA_WIDTH-1:0]  mask_q, mask_d;
   logic [15:0]            fcnt_q, fcnt_d;
   logic [ADDR_WIDTH-1:0]  faddr_q, faddr_d;
   logic [DATA_WIDTH-1:0]  fexp_q, fexp_d;
   logic [DATA_WIDTH-1:0]  fact_q, fact_d;
   logic                   pass_q, pass_d;
   logic [NUM_CHIPS-1:0]   csb0_q, csb0_d;
   logic                   web0_q, web0_d;
   logic [WMASK_WIDTH-1:0] wmask0_q, wmask0_d;
   logic [DATA_WIDTH-1:0]  din0_q, din0_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   advance;
   logic                   last_of_elem;
   logic                   mismatch;
   logic [DATA_WIDTH-1:0]  exp_data;

   // Element table: E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 r0
   function automatic logic el_reads(input logic [2:0] e);
      return e != 3'd0;
   endfunction

   function automatic logic el_writes(input logic [2:0] e);
      return e != 3'd5;
   endfunction

   function automatic logic el_desc(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   function automatic logic el_rval(input logic [2:0] e);
      return (e == 3'd2) || (e == 3'd4);
   endfunction

   function automatic logic el_wval(input logic [2:0] e);
      return (e == 3'd1) || (e == 3'd3);
   endfunction

   function automatic state_e el_first(input logic [2:0] e);
      return el_reads(e) ? StRead : StWrite;
   endfunction

   always_comb begin
      state_d  = state_q;
      elem_d   = elem_q;
      addr_d   = addr_q;
      last_d   = last_q;
      wait_d   = wait_q;
      chip_d   = chip_q;
      mask_d   = mask_q;
      fcnt_d   = fcnt_q;
      faddr_d  = faddr_q;
      fexp_d   = fexp_q;
      fact_d   = fact_q;
      pass_d   = pass_q;
      advance  = 1'b0;
      exp_data = {DATA_WIDTH{el_rval(elem_q)}};
      mismatch = |((rdata_in ^ exp_data) & mask_q);
      last_of_elem = el_desc(elem_q) ? (addr_q == '0) : (addr_q == last_q);

      case (state_q)
         StIdle: begin
            if (start && !abort) begin
               chip_d  = chip_sel;
               last_d  = last_addr;
               mask_d  = cmp_mask;
               pass_d  = 1'b0;
               fcnt_d  = '0;
               faddr_d = '0;
               fexp_d  = '0;
               fact_d  = '0;
               elem_d  = 3'd0;
               addr_d  = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (abort) state_d = StIdle;
            else       advance = 1'b1;
         end
         StRead: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               state_d = StWait;
               wait_d  = CntW'(1);
            end
         end
         StWait: begin
            if (abort) begin
               state_d = StIdle;
            end else if (wait_q == CntW'(READ_LATENCY)) begin
               if (mismatch) begin
                  if (fcnt_q == '0) begin
                     faddr_d = addr_q;
                     fexp_d  = exp_data & mask_q;
                     fact_d  = rdata_in & mask_q;
                  end
                  if (fcnt_q != '1) fcnt_d = fcnt_q + 16'd1;
               end
               if (el_writes(elem_q)) state_d = StWrite;
               else                   advance = 1'b1;
            end else begin
               wait_d = wait_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Next address/element is chosen in the last op cycle, so no bubble cycles appear.
      if (advance) begin
         if (!last_of_elem) begin
            addr_d  = el_desc(elem_q) ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            state_d = el_first(elem_q);
         end else if (elem_q == 3'd5) begin
            state_d = StDone;
         end else begin
            elem_d  = elem_q + 3'd1;
            addr_d  = el_desc(elem_d) ? last_q : '0;
            state_d = el_first(elem_d);
         end
      end

      if (state_d == StDone) pass_d = (fcnt_d == '0);

      csb0_d   = ((state_d == StRead) || (state_d == StWrite)) ?
                 ~(NUM_CHIPS'(1) << chip_d) : '1;
      web0_d   = (state_d != StWrite);
      wmask0_d = (state_d == StWrite) ? '1 : '0;
      din0_d   = (state_d == StWrite) ? {DATA_WIDTH{el_wval(elem_d)}} : '0;
      busy_d   = (state_d == StWrite) || (state_d == StRead) || (state_d == StWait);
      done_d   = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         elem_q   <= '0;
         addr_q   <= '0;
         last_q   <= '0;
         wait_q   <= '0;
         chip_q   <= '0;
         mask_q   <= '0;
         fcnt_q   <= '0;
         faddr_q  <= '0;
         fexp_q   <= '0;
         fact_q   <= '0;
         pass_q   <= 1'b0;
         csb0_q   <= '1;
         web0_q   <= 1'b1;
         wmask0_q <= '0;
         din0_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         elem_q   <= elem_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
         wait_q   <= wait_d;
         chip_q   <= chip_d;
         mask_q   <= mask_d;
         fcnt_q   <= fcnt_d;
         faddr_q  <= faddr_d;
         fexp_q   <= fexp_d;
         fact_q   <= fact_d;
         pass_q   <= pass_d;
         csb0_q   <= csb0_d;
         web0_q   <= web0_d;
         wmask0_q <= wmask0_d;
         din0_q   <= din0_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign addr0         = addr_q;
   assign din0          = din0_q;
   assign web0          = web0_q;
   assign wmask0        = wmask0_q;
   assign csb0          = csb0_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign fail_count    = fcnt_q;
   assign fail_addr     = faddr_q;
   assign fail_expected = fexp_q;
   assign fail_actual   = fact_q;
   assign march_elem    = elem_q;

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test engine for the test-chip SRAM macros.
- Drives the shared port-0 control/data bus (addr0, din0, web0, wmask0, one-hot-low csb0) and runs a March C- sequence on one selected macro.
- Compares the registered read data returned from that macro and reports pass/fail plus first-failure details.
- Sits alongside the scan/LA control logic, in front of the SRAM port-0 mux.

Parameters:
ADDR_WIDTH, 16, address bus width
DATA_WIDTH, 32, data bus width
WMASK_WIDTH, 4, write-mask width
NUM_CHIPS, 16, number of csb0 lines
READ_LATENCY, 2, cycles from read-request cycle to valid rdata_in (SRAM dout plus capture register); minimum 1

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse; ignored while busy
abort  in  1  synchronous abort
chip_sel  in  4  macro under test, index into csb0
last_addr  in  ADDR_WIDTH  highest address tested; test range is 0..last_addr
cmp_mask  in  DATA_WIDTH  bits compared (e.g. 0x000000FF for 8-bit macro)
rdata_in  in  DATA_WIDTH  registered read data of the selected macro
addr0  out  ADDR_WIDTH  SRAM address
din0  out  DATA_WIDTH  SRAM write data
web0  out  1  write enable, active low
wmask0  out  WMASK_WIDTH  write mask
csb0  out  NUM_CHIPS  chip selects, active low
busy  out  1  test in progress
done  out  1  one-cycle pulse at normal completion
pass  out  1  result, valid after done
fail_count  out  16  mismatch count, saturating
fail_addr  out  ADDR_WIDTH  address of first mismatch
fail_expected  out  DATA_WIDTH  expected data at first mismatch (masked)
fail_actual  out  DATA_WIDTH  rdata_in at first mismatch (masked)
march_elem  out  3  current element 0..5

Behaviour:
- Reset values: csb0 all ones, web0=1, addr0=0, din0=0, wmask0=0, busy=0, done=0, pass=0, fail_count=0, fail_*=0, march_elem=0, FSM in IDLE.
- Reset asserted mid-test: outputs return to reset values immediately.
- Elements (0 = all-zeros data, 1 = all-ones data):
  - E0: ascending w0
  - E1: ascending r0, w1
  - E2: ascending r1, w0
  - E3: descending r0, w1
  - E4: descending r1, w0
  - E5: ascending r0
  - Ascending runs 0..last_addr. Descending runs last_addr..0. There is no wrap.
- FSM states: IDLE, WRITE, READ, WAIT, NEXT, DONE.
- start in IDLE:
  - Clears pass, fail_count and fail_*, and latches chip_sel, last_addr and cmp_mask.
  - busy rises the next cycle; the first op is driven in that cycle.
- Request cycle: csb0[chip_sel]=0 and all other csb0 bits =1. Outside request cycles csb0 is all ones.
- WRITE: one cycle with web0=0, wmask0 all ones, din0 = pattern.
- READ: one cycle with web0=1, wmask0=0, din0=0. It is followed by READ_LATENCY WAIT cycles with csb0 all ones.
  - rdata_in is sampled at the end of the last WAIT cycle.
  - Mismatch condition: (rdata_in ^ expected) & cmp_mask != 0.
  - On mismatch, fail_count increments, saturating at 0xFFFF.
  - fail_addr, fail_expected and fail_actual are captured only on the first mismatch.
- Read-write element: WRITE to the same address follows the compare in the next cycle.
- Cycles per address: w = 1, r = 1+READ_LATENCY, rw = 2+READ_LATENCY.
- Total cycles: N + 4N(2+RL) + N(1+RL) with N = last_addr+1. For RL=2 this is 20N.
- Address and element advance:
  - NEXT is folded into the last op cycle, so there are no bubble cycles between addresses or elements.
  - addr0 holds its value between requests.
  - march_elem updates in the first cycle of each element.
- DONE:
  - Entered the cycle after the final E5 compare.
  - done=1 for exactly one cycle, pass = (fail_count==0), busy=0 in the same cycle.
  - Then returns to IDLE. pass and fail_* hold until the next start.
- last_addr=0: every element touches address 0 only; the run is 20 cycles for RL=2.
- abort while busy:
  - The FSM goes to IDLE next cycle with csb0 all ones, busy=0, no done pulse, pass=0.
  - fail_* and fail_count hold.
- abort and start in the same IDLE cycle: abort wins and the test does not start.
- start while busy: ignored.

Test Plan:
- Ideal memory model (RL=2), chip_sel=3, last_addr=3, cmp_mask=0xFFFFFFFF → done pulse 80 cycles after first op, pass=1, fail_count=0, csb0 only ever 0xFFF7 or 0xFFFF.
- Model with bit 5 of address 2 stuck-at-1 → pass=0, fail_count=3 (E1 r0, E3 r0, E5 r0), fail_addr=2, fail_expected=0x00000000, fail_actual=0x00000020.
- Same fault with cmp_mask=0x0000000F → pass=1, fail_count=0.
- Descending check: last_addr=5 → in E3, addr0 sequence on requests is 5,5,4,4,3,3,... (read, write per address) ending at 0; no access beyond 5.
- abort asserted in E2 → busy=0 and csb0=all ones next cycle, no done, further start runs normally to pass=1.
- resetn pulsed low mid-E1 → all outputs at reset values asynchronously; start after release completes with pass=1.
